// File: rtl/lsu_ctrl.sv
// Load/store control stage: aligns one op at a time to the 64-bit memory word,
// drives the memory pins for LATENCY cycles, extends load data and hands the
// result to writeback over a valid/ready handshake. All outputs are registered.
module lsu_ctrl #(
  parameter int unsigned LATENCY = 1  // 1..15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_store_data,
  output logic        o_mem_ren,
  output logic [63:0] o_mem_raddr,
  input  logic [63:0] i_mem_rdata,
  output logic        o_mem_wen,
  output logic [63:0] o_mem_waddr,
  output logic [63:0] o_mem_wdata,
  output logic [7:0]  o_mem_mask,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_out_data,
  output logic        o_out_err
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  localparam logic [3:0] LatLast = 4'(LATENCY - 1);

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  r_off, w_off_nxt;
  logic [2:0]  r_funct3, w_funct3_nxt;
  logic        r_is_load, w_is_load_nxt;
  logic        r_in_ready, w_in_ready_nxt;
  logic        r_ren, w_ren_nxt;
  logic        r_wen, w_wen_nxt;
  logic [63:0] r_raddr, w_raddr_nxt;
  logic [63:0] r_waddr, w_waddr_nxt;
  logic [63:0] r_wdata, w_wdata_nxt;
  logic [7:0]  r_mask, w_mask_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic [63:0] r_out_data, w_out_data_nxt;
  logic        r_out_err, w_out_err_nxt;

  logic [2:0]  w_off;
  logic        w_misalign;
  logic        w_err;
  logic [7:0]  w_lane_mask;
  logic [63:0] w_trim;
  logic [63:0] w_sh;
  logic [63:0] w_load_val;

  // Decode the offered op: alignment, legality and byte lanes it covers.
  always_comb begin
    w_off       = i_addr[2:0];
    w_misalign  = 1'b0;
    w_lane_mask = 8'h01;
    unique case (i_funct3[1:0])
      2'd0: begin w_misalign = 1'b0;              w_lane_mask = 8'h01; end
      2'd1: begin w_misalign = w_off[0];          w_lane_mask = 8'h03; end
      2'd2: begin w_misalign = |w_off[1:0];       w_lane_mask = 8'h0F; end
      default: begin w_misalign = |w_off;         w_lane_mask = 8'hFF; end
    endcase
    w_err = w_misalign | (i_is_load & i_is_store) | (i_is_store & i_funct3[2]) |
            (i_funct3 == 3'd7);
    // Drop store operand bytes beyond the access size before lane shifting.
    w_trim = '0;
    for (int b = 0; b < 8; b++) begin
      w_trim[8*b +: 8] = i_store_data[8*b +: 8] & {8{w_lane_mask[b]}};
    end
  end

  // Shift returned data down to the accessed bytes and extend per funct3.
  always_comb begin
    w_sh = i_mem_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'd0:    w_load_val = {{56{w_sh[7]}}, w_sh[7:0]};
      3'd1:    w_load_val = {{48{w_sh[15]}}, w_sh[15:0]};
      3'd2:    w_load_val = {{32{w_sh[31]}}, w_sh[31:0]};
      3'd3:    w_load_val = w_sh;
      3'd4:    w_load_val = {56'd0, w_sh[7:0]};
      3'd5:    w_load_val = {48'd0, w_sh[15:0]};
      3'd6:    w_load_val = {32'd0, w_sh[31:0]};
      default: w_load_val = '0;
    endcase
  end

  // Next-state and next-output logic; everything holds unless changed.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_off_nxt       = r_off;
    w_funct3_nxt    = r_funct3;
    w_is_load_nxt   = r_is_load;
    w_in_ready_nxt  = r_in_ready;
    w_ren_nxt       = r_ren;
    w_wen_nxt       = r_wen;
    w_raddr_nxt     = r_raddr;
    w_waddr_nxt     = r_waddr;
    w_wdata_nxt     = r_wdata;
    w_mask_nxt      = r_mask;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_err_nxt   = r_out_err;
    case (r_state)
      StIdle: begin
        w_in_ready_nxt = 1'b1;
        if (i_in_valid) begin
          w_in_ready_nxt = 1'b0;
          w_off_nxt      = w_off;
          w_funct3_nxt   = i_funct3;
          w_is_load_nxt  = i_is_load;
          w_out_data_nxt = '0;
          w_out_err_nxt  = 1'b0;
          if (w_err || (!i_is_load && !i_is_store)) begin
            w_state_nxt     = StDone;
            w_out_valid_nxt = 1'b1;
            w_out_err_nxt   = w_err;
          end else begin
            w_state_nxt = StAccess;
            w_cnt_nxt   = LatLast;
            w_ren_nxt   = i_is_load;
            w_wen_nxt   = i_is_store;
            w_raddr_nxt = {i_addr[63:3], 3'b000};
            w_waddr_nxt = {i_addr[63:3], 3'b000};
            w_mask_nxt  = i_is_store ? (w_lane_mask << w_off) : 8'h00;
            w_wdata_nxt = i_is_store ? (w_trim << {w_off, 3'b000}) : 64'd0;
          end
        end
      end
      StAccess, StWait: begin
        // Single write pulse: wen only in the first access cycle.
        w_wen_nxt = 1'b0;
        if (r_cnt == 4'd0) begin
          w_state_nxt     = StDone;
          w_ren_nxt       = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = r_is_load ? w_load_val : 64'd0;
        end else begin
          w_state_nxt = StWait;
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      default: begin
        if (i_out_ready) begin
          w_state_nxt     = StIdle;
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_off       <= '0;
      r_funct3    <= '0;
      r_is_load   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      r_raddr     <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_off       <= w_off_nxt;
      r_funct3    <= w_funct3_nxt;
      r_is_load   <= w_is_load_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_ren       <= w_ren_nxt;
      r_wen       <= w_wen_nxt;
      r_raddr     <= w_raddr_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_mask      <= w_mask_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_err   <= w_out_err_nxt;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_mem_ren   = r_ren;
  assign o_mem_wen   = r_wen;
  assign o_mem_raddr = r_raddr;
  assign o_mem_waddr = r_waddr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_mask  = r_mask;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_err   = r_out_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one instance with LATENCY=1 (d1_*) and one with
// LATENCY=3 (d3_*) share the input stimulus; each test resets both first.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] store_data;
  logic [63:0] mem_rdata;
  logic        out_ready;

  logic        d1_in_ready, d1_ren, d1_wen, d1_valid, d1_err;
  logic [63:0] d1_raddr, d1_waddr, d1_wdata, d1_data;
  logic [7:0]  d1_mask;
  logic        d3_in_ready, d3_ren, d3_wen, d3_valid, d3_err;
  logic [63:0] d3_raddr, d3_waddr, d3_wdata, d3_data;
  logic [7:0]  d3_mask;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_ctrl #(.LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(d1_in_ready),
    .i_is_load(is_load), .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr),
    .i_store_data(store_data), .o_mem_ren(d1_ren), .o_mem_raddr(d1_raddr),
    .i_mem_rdata(mem_rdata), .o_mem_wen(d1_wen), .o_mem_waddr(d1_waddr),
    .o_mem_wdata(d1_wdata), .o_mem_mask(d1_mask), .o_out_valid(d1_valid),
    .i_out_ready(out_ready), .o_out_data(d1_data), .o_out_err(d1_err)
  );

  lsu_ctrl #(.LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(d3_in_ready),
    .i_is_load(is_load), .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr),
    .i_store_data(store_data), .o_mem_ren(d3_ren), .o_mem_raddr(d3_raddr),
    .i_mem_rdata(mem_rdata), .o_mem_wen(d3_wen), .o_mem_waddr(d3_waddr),
    .o_mem_wdata(d3_wdata), .o_mem_mask(d3_mask), .o_out_valid(d3_valid),
    .i_out_ready(out_ready), .o_out_data(d3_data), .o_out_err(d3_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    is_load = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; store_data = '0;
    step();
    rst = 1'b0;
  endtask

  // Offer one op for one edge; returns in the cycle after the accepting edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] sd);
    in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%0h exp=1", d1_in_ready); end
    n_checks++;
    if ({d1_ren, d1_wen, d1_valid, d1_err} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_ctl got=%b exp=0000", {d1_ren, d1_wen, d1_valid, d1_err});
    end
    n_checks++;
    if ({d1_data, d1_mask, d1_wdata} !== '0) begin
      n_fail++; $display("FAIL rst_data got=%h/%h/%h exp=0", d1_data, d1_mask, d1_wdata);
    end
    step();
  endtask

  task automatic test_store_byte();
    do_reset();
    issue(1'b0, 1'b1, 3'd0, 64'h8000_0003, 64'h1122_3344_5566_77AB);
    @(negedge clk);
    n_checks++;
    if (d1_wen !== 1'b1 || d1_ren !== 1'b0) begin
      n_fail++; $display("FAIL sb_en got wen=%0h ren=%0h exp wen=1 ren=0", d1_wen, d1_ren);
    end
    n_checks++;
    if (d1_waddr !== 64'h8000_0000) begin n_fail++; $display("FAIL sb_waddr got=%h exp=80000000", d1_waddr); end
    n_checks++;
    if (d1_mask !== 8'h08) begin n_fail++; $display("FAIL sb_mask got=%h exp=08", d1_mask); end
    n_checks++;
    if (d1_wdata !== 64'h0000_0000_AB00_0000) begin
      n_fail++; $display("FAIL sb_wdata got=%h exp=00000000ab000000", d1_wdata);
    end
    n_checks++;
    if (d1_valid !== 1'b0) begin n_fail++; $display("FAIL sb_early_valid got=%0h exp=0", d1_valid); end
    step();
    @(negedge clk);
    n_checks++;
    if (d1_wen !== 1'b0) begin n_fail++; $display("FAIL sb_single_pulse got=%0h exp=0", d1_wen); end
    n_checks++;
    if ({d1_valid, d1_err} !== 2'b10 || d1_data !== 64'd0) begin
      n_fail++; $display("FAIL sb_done got v/e=%b data=%h exp 10/0", {d1_valid, d1_err}, d1_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d1_valid !== 1'b0 || d1_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL sb_release got v=%0h rdy=%0h exp 0/1", d1_valid, d1_in_ready);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s [6] = '{3'd1, 3'd5, 3'd0, 3'd4, 3'd2, 3'd6};
    logic [63:0] adrs[6] = '{64'h8000_0006, 64'h8000_0006, 64'h8000_0007,
                             64'h8000_0006, 64'h8000_0004, 64'h8000_0004};
    logic [63:0] exps[6] = '{64'hFFFF_FFFF_FFFF_8123, 64'h0000_0000_0000_8123,
                             64'hFFFF_FFFF_FFFF_FF81, 64'h0000_0000_0000_0023,
                             64'hFFFF_FFFF_8123_0000, 64'h0000_0000_8123_0000};
    do_reset();
    mem_rdata = 64'h8123_0000_0000_0000;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 1'b0, f3s[i], adrs[i], 64'd0);
      @(negedge clk);
      n_checks++;
      if (d1_ren !== 1'b1 || d1_raddr !== 64'h8000_0000) begin
        n_fail++; $display("FAIL ld%0d_rd got ren=%0h raddr=%h exp 1/80000000", i, d1_ren, d1_raddr);
      end
      step();
      @(negedge clk);
      n_checks++;
      if (d1_valid !== 1'b1 || d1_err !== 1'b0 || d1_data !== exps[i]) begin
        n_fail++;
        $display("FAIL ld%0d_data got v=%0h e=%0h data=%h exp 1/0/%h", i, d1_valid, d1_err,
                 d1_data, exps[i]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_errors();
    logic        lds[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        sts[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s[5] = '{3'd2, 3'd3, 3'd4, 3'd7, 3'd3};
    logic [63:0] ads[5] = '{64'h8000_0002, 64'h8000_0000, 64'h8000_0000, 64'h8000_0000,
                            64'h8000_0000};
    logic        ers[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      issue(lds[i], sts[i], f3s[i], ads[i], 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      n_checks++;
      if ({d1_ren, d1_wen} !== 2'b00) begin
        n_fail++; $display("FAIL err%0d_noaccess got ren/wen=%b exp 00", i, {d1_ren, d1_wen});
      end
      n_checks++;
      if (d1_valid !== 1'b1 || d1_err !== ers[i] || d1_data !== 64'd0) begin
        n_fail++;
        $display("FAIL err%0d_done got v=%0h e=%0h data=%h exp 1/%0h/0", i, d1_valid, d1_err,
                 d1_data, ers[i]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_latency3();
    do_reset();
    mem_rdata = 64'h1111_1111_1111_1111;
    issue(1'b1, 1'b0, 3'd3, 64'h8000_0008, 64'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (d3_ren !== 1'b1 || d3_raddr !== 64'h8000_0008 || d3_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL lat3_c%0d got ren=%0h raddr=%h v=%0h exp 1/80000008/0", c, d3_ren,
                 d3_raddr, d3_valid);
      end
      mem_rdata = (c == 1) ? 64'h2222_2222_2222_2222 : 64'h0123_4567_89AB_CDEF;
      step();
    end
    @(negedge clk);
    n_checks++;
    if (d3_ren !== 1'b0 || d3_valid !== 1'b1 || d3_data !== 64'h0123_4567_89AB_CDEF) begin
      n_fail++;
      $display("FAIL lat3_done got ren=%0h v=%0h data=%h exp 0/1/0123456789abcdef", d3_ren,
               d3_valid, d3_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_rdata = 64'hA5A5_0000_1234_5678;
    issue(1'b1, 1'b0, 3'd3, 64'h8000_0000, 64'd0);
    step();
    mem_rdata = 64'h0;
    in_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'd3;
    addr = 64'h8000_0010; store_data = 64'h55;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (d1_valid !== 1'b1 || d1_data !== 64'hA5A5_0000_1234_5678 || d1_in_ready !== 1'b0 ||
          d1_wen !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got v=%0h data=%h rdy=%0h wen=%0h exp 1/a5a5000012345678/0/0",
                 c, d1_valid, d1_data, d1_in_ready, d1_wen);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d1_valid !== 1'b0 || d1_in_ready !== 1'b1 || d1_wen !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got v=%0h rdy=%0h wen=%0h exp 0/1/0", d1_valid,
                         d1_in_ready, d1_wen);
    end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d1_wen !== 1'b1 || d1_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_next_accept got wen=%0h rdy=%0h exp 1/0", d1_wen, d1_in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(1'b1, 1'b0, 3'd3, 64'h8000_0000, 64'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d3_ren !== 1'b0 || d3_valid !== 1'b0 || d3_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_state got ren=%0h v=%0h rdy=%0h exp 0/0/1", d3_ren,
                         d3_valid, d3_in_ready);
    end
    issue(1'b0, 1'b1, 3'd3, 64'h8000_0010, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    n_checks++;
    if (d3_wen !== 1'b1 || d3_ren !== 1'b0 || d3_mask !== 8'hFF || d3_waddr !== 64'h8000_0010 ||
        d3_wdata !== 64'h0123_4567_89AB_CDEF) begin
      n_fail++;
      $display("FAIL rmid_sd got wen=%0h ren=%0h mask=%h waddr=%h wdata=%h", d3_wen, d3_ren,
               d3_mask, d3_waddr, d3_wdata);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (d3_wen !== 1'b0 || d3_mask !== 8'hFF) begin
      n_fail++; $display("FAIL rmid_pulse got wen=%0h mask=%h exp 0/ff", d3_wen, d3_mask);
    end
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (d3_valid !== 1'b1 || d3_err !== 1'b0 || d3_data !== 64'd0) begin
      n_fail++; $display("FAIL rmid_done got v=%0h e=%0h data=%h exp 1/0/0", d3_valid, d3_err,
                         d3_data);
    end
  endtask

  initial begin
    mem_rdata = '0;
    test_reset();
    test_store_byte();
    test_load_extend();
    test_errors();
    test_latency3();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the DPI-backed physical-memory block.
- Takes one memory op at a time from the execute stage and aligns it to the 64-bit memory word.
- Drives the memory block's ren/wen/raddr/waddr/wdata/mask pins and shifts, then sign- or zero-extends, the returned rdata.
- Hands the result to writeback over a valid/ready handshake.
- Runs a multi-cycle FSM with a configurable memory latency.

Parameters:
- LATENCY, 1, cycles from mem_ren/mem_wen assertion to op completion; legal values are 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  execute stage offers an op.
- in_ready  out  1  block can accept an op.
- is_load  in  1  op is a load.
- is_store  in  1  op is a store.
- funct3  in  3  size/sign: 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU; stores use 0..3 only.
- addr  in  64  byte address.
- store_data  in  64  store operand, right-justified.
- mem_ren  out  1  read enable to memory.
- mem_raddr  out  64  8-byte-aligned read address.
- mem_rdata  in  64  read data from memory.
- mem_wen  out  1  write enable to memory.
- mem_waddr  out  64  8-byte-aligned write address.
- mem_wdata  out  64  lane-shifted write data.
- mem_mask  out  8  byte-lane write mask.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts the result.
- out_data  out  64  extended load result; 0 for stores.
- out_err  out  1  misaligned, illegal, or conflicting op.

Behaviour:
- All outputs are registered. On reset, every output is 0 except in_ready=1, and the FSM goes to IDLE.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch the op and compute off=addr[2:0] and size=1<<funct3[1:0].
  - Error when: off is not a multiple of size, or is_load and is_store are both 1, or is_store with funct3>3, or funct3==7. An erroring op goes to DONE with out_err=1, out_data=0, and no memory access.
  - Neither is_load nor is_store: go to DONE with out_err=0, out_data=0, no access.
  - Otherwise go to ACCESS.
- ACCESS and WAIT (LATENCY cycles total, counted by an internal down-counter):
  - raddr and waddr are addr with bits [2:0] cleared.
  - Load: mem_ren=1 for all LATENCY cycles, with mem_raddr stable. mem_rdata is sampled at the end of the last cycle.
  - Store: mem_wen=1 in the first cycle only, so exactly one write occurs. mem_mask = ((1<<size)-1)<<off. mem_wdata = store_data<<(8*off). These stay stable until DONE.
  - When LATENCY=1, WAIT is skipped.
- Load extraction: sh = mem_rdata>>(8*off); keep the low size bytes.
  - funct3 0..2: sign-extend from the top kept bit.
  - funct3 3: full 64 bits.
  - funct3 4..6: zero-extend.
- DONE:
  - out_valid=1, with out_data and out_err held stable while out_ready=0.
  - On out_ready, go to IDLE with out_valid=0 next cycle.
  - in_ready=0 in every state except IDLE; there is no accept in the same cycle as completion.
- Timing: an op accepted at edge T gives mem_ren/mem_wen high in cycle T+1 and out_valid in cycle T+1+LATENCY. Error and no-op cases give out_valid in cycle T+1.
- mem_ren and mem_wen are never high in the same cycle. Both are 0 in IDLE and DONE.
- Reset mid-op: state returns to IDLE at that edge and all enables drop. A write pulse already driven is not retracted, and a partially completed load is discarded.

Test Plan:
- SB, addr=0x80000003, store_data=0x..AB, LATENCY=1 -> one cycle with mem_wen=1, mem_waddr=0x80000000, mem_mask=0x08, mem_wdata=0x00000000AB000000; out_valid 2 cycles after accept, out_err=0.
- LH, addr=0x80000006, mem_rdata=0x8123_0000_0000_0000 -> out_data=0xFFFFFFFFFFFF8123. LHU at the same address -> 0x0000000000008123.
- LW, addr=0x80000002 -> no mem_ren/mem_wen pulse; out_valid next cycle with out_err=1, out_data=0.
- LATENCY=3, LD at 0x80000008 -> mem_ren high exactly 3 cycles; out_data equals mem_rdata at the 3rd cycle; out_valid at T+4.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data and in_ratio stay stable with in_ready=0; a new in_valid is ignored until 1 cycle after out_ready.
- Assert rst during WAIT of a load (LATENCY=3) -> next cycle mem_ren=0, out_valid=0, in_ready=1; a following SD at 0x80000010 completes normally with mem_mask=0xFF.
